// File: rtl/adpll_pkg.sv
// -----------------------------------------------------------------------------
// adpll_pkg
// Shared definitions for the TDC loop filter slice:
//   - default widths for the TDC code, decoded count, accumulator and DCO word
//   - loop filter FSM state encoding
//   - width-generic signed saturation and unsigned clamp helpers. They work on
//     a 64-bit container so callers can size-cast the result to any width.
// -----------------------------------------------------------------------------
package adpll_pkg;

  localparam int TDC_W_DEF = 32;  // thermometer code width
  localparam int CNT_W_DEF = 6;   // decoded count width, holds 0..TDC_W
  localparam int ACC_W_DEF = 16;  // signed integrator / PI sum width
  localparam int DCO_W_DEF = 8;   // DCO tuning word width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no comparison in progress
    ST_TRACK   = 2'd1,  // TDC holds a nonzero count
    ST_CAPTURE = 2'd2,  // error captured, integrator updating
    ST_UPDATE  = 2'd3   // DCO word updated this cycle
  } lf_state_e;

  // Saturate a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned     w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Clamp a signed value into the unsigned range 0 .. 2^w-1.
  function automatic logic [63:0] clamp_unsigned(input logic signed [63:0] x,
                                                 input int unsigned     w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (x[63]) return '0;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/tdc_pi_loop_filter_if.sv
// -----------------------------------------------------------------------------
// tdc_pi_loop_filter_if
// Bundle between the TDC / loop controller and the PI loop filter.
//   up_error  : thermometer code of the UP pulse width        (master -> slave)
//   dwn_error : thermometer code of the DWN pulse width       (master -> slave)
//   freeze    : hold the integrator, P path still active      (master -> slave)
//   dco_code  : DCO tuning word, higher = faster DCO          (slave -> master)
//   dco_valid : one-cycle pulse when dco_code updates         (slave -> master)
//   phase_err : signed error of the last captured comparison  (slave -> master)
//   lock      : loop locked indicator                         (slave -> master)
// -----------------------------------------------------------------------------
interface tdc_pi_loop_filter_if
  import adpll_pkg::*;
#(
  parameter int TDC_W = TDC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DCO_W = DCO_W_DEF
);

  logic [TDC_W-1:0]        up_error;
  logic [TDC_W-1:0]        dwn_error;
  logic                    freeze;
  logic [DCO_W-1:0]        dco_code;
  logic                    dco_valid;
  logic signed [CNT_W:0]   phase_err;
  logic                    lock;

  modport master (
    output up_error, dwn_error, freeze,
    input  dco_code, dco_valid, phase_err, lock
  );

  modport slave (
    input  up_error, dwn_error, freeze,
    output dco_code, dco_valid, phase_err, lock
  );

endinterface

// File: rtl/tdc_pi_loop_filter_therm_popcount.sv
// -----------------------------------------------------------------------------
// therm_popcount
// Counts the ones in a thermometer code. A plain popcount rather than a
// leading-one search, so isolated bubbles in the code only cost one count
// instead of corrupting the result.
//   i_code  in  TDC_W  thermometer code
//   o_count out CNT_W  number of set bits (0..TDC_W), combinational
// -----------------------------------------------------------------------------
module therm_popcount #(
  parameter int TDC_W = 32,
  parameter int CNT_W = 6
) (
  input  logic [TDC_W-1:0] i_code,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] w_count;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < TDC_W; i++) begin
      w_count = w_count + CNT_W'(i_code[i]);
    end
  end

  assign o_count = w_count;

endmodule

// File: rtl/tdc_pi_loop_filter.sv
// -----------------------------------------------------------------------------
// tdc_pi_loop_filter
// Digital loop filter behind the thermometer-coded TDC phase detector.
// Decodes the UP/DWN codes, captures one signed phase error per comparison
// (when the TDC clears), runs a saturating PI filter and drives the DCO word
// plus a lock flag.
//   clk     in   system clock (same clock as the TDC shift registers)
//   reset   in   synchronous, active-high
//   io_tdc  slave side of tdc_pi_loop_filter_if (codes/freeze in,
//           dco_code/dco_valid/phase_err/lock out)
// Timing, E = cycle in which the cleared TDC is seen:
//   E+1 : phase_err and lock show the new comparison, integrator updates
//   E+2 : dco_code carries the new word, dco_valid high for this cycle only
// -----------------------------------------------------------------------------
module tdc_pi_loop_filter
  import adpll_pkg::*;
#(
  parameter int TDC_W    = TDC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int KP       = 4,
  parameter int KI       = 1,
  parameter int FRAC     = 3,
  parameter int DCO_W    = DCO_W_DEF,
  parameter int DCO_INIT = 128,
  parameter int LOCK_TOL = 1,
  parameter int LOCK_CNT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tdc_pi_loop_filter_if.slave  io_tdc
);

  localparam int SUM_W = ACC_W + 2;   // headroom for every intermediate sum
  localparam int ERR_W = CNT_W + 1;
  localparam int LCW   = $clog2(LOCK_CNT + 1);

  localparam logic signed [ERR_W-1:0] TOL_S    = ERR_W'(LOCK_TOL);
  localparam logic [LCW-1:0]          LOCK_MAX = LCW'(LOCK_CNT);

  // ---------------------------------------------------------------- decode
  logic [CNT_W-1:0] w_up_pop;
  logic [CNT_W-1:0] w_dwn_pop;

  therm_popcount #(.TDC_W(TDC_W), .CNT_W(CNT_W)) u_up_pop (
    .i_code  (io_tdc.up_error),
    .o_count (w_up_pop)
  );

  therm_popcount #(.TDC_W(TDC_W), .CNT_W(CNT_W)) u_dwn_pop (
    .i_code  (io_tdc.dwn_error),
    .o_count (w_dwn_pop)
  );

  logic [CNT_W-1:0] r_up_cnt;
  logic [CNT_W-1:0] r_dwn_cnt;
  logic [CNT_W-1:0] r_prev_up;
  logic [CNT_W-1:0] r_prev_dwn;

  logic                    w_cur_nz;
  logic                    w_prev_nz;
  logic                    w_event;
  logic signed [ERR_W-1:0] w_err;
  logic                    w_in_lock;

  // A comparison ends when the TDC clears after holding a count; the held
  // counts (one cycle old) are the measurement.
  assign w_cur_nz  = (r_up_cnt != '0) || (r_dwn_cnt != '0);
  assign w_prev_nz = (r_prev_up != '0) || (r_prev_dwn != '0);
  assign w_event   = w_prev_nz && !w_cur_nz;
  assign w_err     = $signed({1'b0, r_prev_up}) - $signed({1'b0, r_prev_dwn});
  assign w_in_lock = (w_err <= TOL_S) && (w_err >= -TOL_S);

  // ---------------------------------------------------------------- FSM
  lf_state_e r_state;
  lf_state_e w_state_next;
  logic      w_capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Events can only arrive while a count has been seen, i.e. in TRACK or in
  // UPDATE (a new comparison may finish two cycles after the previous one).
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cur_nz) w_state_next = ST_TRACK;
      end
      ST_TRACK: begin
        if (w_event) begin
          w_state_next = ST_CAPTURE;
          w_capture    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (w_event) begin
          w_state_next = ST_CAPTURE;
          w_capture    = 1'b1;
        end else if (w_cur_nz) begin
          w_state_next = ST_TRACK;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- PI path
  logic signed [ERR_W-1:0] r_phase_err;   // also the stage-1 operand
  logic                    r_s1_valid;
  logic signed [ACC_W-1:0] r_integ;
  logic [DCO_W-1:0]        r_dco_code;
  logic                    r_dco_valid;
  logic [LCW-1:0]          r_lock_cnt;

  logic signed [SUM_W-1:0] w_err_ext;
  logic signed [SUM_W-1:0] w_integ_sum;
  logic signed [ACC_W-1:0] w_integ_sat;
  logic signed [ACC_W-1:0] w_integ_new;
  logic signed [SUM_W-1:0] w_p;
  logic signed [SUM_W-1:0] w_u_sum;
  logic signed [ACC_W-1:0] w_u;
  logic signed [SUM_W-1:0] w_dco_sum;
  logic [DCO_W-1:0]        w_dco_new;

  assign w_err_ext   = SUM_W'(r_phase_err);
  assign w_integ_sum = SUM_W'(r_integ) + (w_err_ext * SUM_W'(KI));
  assign w_integ_sat = ACC_W'(sat_signed(64'(w_integ_sum), ACC_W));
  assign w_integ_new = io_tdc.freeze ? r_integ : w_integ_sat;

  // The proportional term rides on the freshly updated integrator so the
  // DCO word reflects this comparison in full.
  assign w_p       = w_err_ext * SUM_W'(KP);
  assign w_u_sum   = SUM_W'(w_integ_new) + w_p;
  assign w_u       = ACC_W'(sat_signed(64'(w_u_sum), ACC_W));
  assign w_dco_sum = SUM_W'(DCO_INIT) + SUM_W'(w_u >>> FRAC);
  assign w_dco_new = DCO_W'(clamp_unsigned(64'(w_dco_sum), DCO_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_cnt    <= '0;
      r_dwn_cnt   <= '0;
      r_prev_up   <= '0;
      r_prev_dwn  <= '0;
      r_phase_err <= '0;
      r_s1_valid  <= 1'b0;
      r_integ     <= '0;
      r_dco_code  <= DCO_W'(DCO_INIT);
      r_dco_valid <= 1'b0;
      r_lock_cnt  <= '0;
    end else begin
      r_up_cnt    <= w_up_pop;
      r_dwn_cnt   <= w_dwn_pop;
      r_prev_up   <= r_up_cnt;
      r_prev_dwn  <= r_dwn_cnt;
      r_s1_valid  <= w_capture;
      r_dco_valid <= r_s1_valid;

      if (w_capture) begin
        r_phase_err <= w_err;
        if (w_in_lock) begin
          if (r_lock_cnt != LOCK_MAX) r_lock_cnt <= r_lock_cnt + 1'b1;
        end else begin
          r_lock_cnt <= '0;
        end
      end

      if (r_s1_valid) begin
        r_integ    <= w_integ_new;
        r_dco_code <= w_dco_new;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign io_tdc.dco_code  = r_dco_code;
  assign io_tdc.dco_valid = r_dco_valid;
  assign io_tdc.phase_err = r_phase_err;
  assign io_tdc.lock      = (r_lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_tdc_pi_loop_filter.sv
// -----------------------------------------------------------------------------
// tb_tdc_pi_loop_filter
// Directed bench for the TDC PI loop filter with hand-computed expectations
// (KP=4, KI=1, FRAC=3, DCO_INIT=128, LOCK_TOL=1, LOCK_CNT=8).
// -----------------------------------------------------------------------------
module tb_tdc_pi_loop_filter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_valid  = 0;

  tdc_pi_loop_filter_if bus ();

  tdc_pi_loop_filter dut (
    .clk    (clk),
    .reset  (reset),
    .io_tdc (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dco_valid === 1'b1) n_valid++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=summary");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic signed [31:0] observed,
                     input logic signed [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end else begin
      $display("ok   %s: %0d", tag, observed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ones(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n && i < 32; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drive(input logic [31:0] up_c, input logic [31:0] dwn_c);
    bus.up_error  = up_c;
    bus.dwn_error = dwn_c;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.up_error  = '0;
    bus.dwn_error = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Clears the TDC code and checks the full comparison pipeline.
  task automatic end_cmp(input string tag, input int exp_err, input int exp_lock,
                         input int exp_dco);
    drive('0, '0);             // now in event cycle E
    tick();                    // E+1
    $display("cmp %s err=%0d lock=%0b", tag, bus.phase_err, bus.lock);
    chk({tag, "_err"},    $signed(bus.phase_err), exp_err);
    chk({tag, "_lock"},   bus.lock, exp_lock);
    chk({tag, "_vld_e1"}, bus.dco_valid, 0);
    tick();                    // E+2
    chk({tag, "_vld_e2"}, bus.dco_valid, 1);
    chk({tag, "_dco"},    bus.dco_code, exp_dco);
    tick();                    // E+3
    chk({tag, "_vld_e3"}, bus.dco_valid, 0);
  endtask

  // Lock sequence: up count, dwn count, error, lock, dco
  int lk_up  [9] = '{1, 3, 0, 1, 3, 0, 1, 3, 4};
  int lk_dwn [9] = '{0, 3, 1, 0, 3, 1, 0, 3, 1};
  int lk_err [9] = '{1, 0, -1, 1, 0, -1, 1, 0, 3};
  int lk_lock[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int lk_dco [9] = '{128, 128, 127, 128, 128, 127, 128, 128, 130};

  initial begin
    int v0;
    bus.up_error  = '0;
    bus.dwn_error = '0;
    bus.freeze    = 1'b0;
    reset         = 1'b1;

    // 1) reset values
    tick(); tick(); tick();
    chk("rst_dco",   bus.dco_code, 128);
    chk("rst_valid", bus.dco_valid, 0);
    chk("rst_lock",  bus.lock, 0);
    chk("rst_err",   $signed(bus.phase_err), 0);
    reset = 1'b0;
    tick();

    // 2) UP ramp to 5 ones: integ 5, u 25, dco 131
    for (int k = 1; k <= 5; k++) drive(ones(k), '0);
    end_cmp("ramp5", 5, 0, 131);
    // DWN 5: integ 0, u -20, -20>>>3 = -3, dco 125
    drive('0, ones(5));
    end_cmp("neg5", -5, 0, 125);

    // 4) lock acquisition and loss
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(ones(lk_up[i]), ones(lk_dwn[i]));
      end_cmp($sformatf("lock%0d", i), lk_err[i], lk_lock[i], lk_dco[i]);
    end

    // 5) freeze holds the integrator; bubbled codes still decode by popcount
    do_reset();
    drive(32'h0000_00F7, '0);                     // 7 ones: integ 7, u 35
    end_cmp("bubble7", 7, 0, 132);
    bus.freeze = 1'b1;
    drive(ones(4), '0);                           // integ 7, u 23
    end_cmp("frz4", 4, 0, 130);
    bus.freeze = 1'b0;
    drive(32'h0000_0003, 32'h0000_0005);          // err 0: integ 7, u 7
    end_cmp("post_frz", 0, 0, 128);

    // 6) reset one cycle after the event discards the update
    do_reset();
    drive(ones(5), '0);
    end_cmp("pre_rst", 5, 0, 131);
    drive(ones(5), '0);
    drive('0, '0);                                // E
    tick();                                       // E+1
    chk("mid_err", $signed(bus.phase_err), 5);
    reset = 1'b1;
    tick();                                       // E+2
    chk("mid_vld",  bus.dco_valid, 0);
    chk("mid_dco",  bus.dco_code, 128);
    chk("mid_perr", $signed(bus.phase_err), 0);
    chk("mid_lock", bus.lock, 0);
    reset = 1'b0;
    tick();
    chk("mid_vld2", bus.dco_valid, 0);
    chk("mid_dco2", bus.dco_code, 128);

    // 3) back-to-back full DWN comparisons: integrator saturates, DCO clamps
    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 1030; i++) begin
      drive('0, '1);
      drive('0, '0);
    end
    tick(); tick(); tick();
    $display("cmp sat integ=%0d dco=%0d", $signed(dut.r_integ), bus.dco_code);
    chk("sat_pulses", n_valid - v0, 1030);
    chk("sat_integ",  $signed(dut.r_integ), -32768);
    chk("sat_dco",    bus.dco_code, 0);
    chk("sat_err",    $signed(bus.phase_err), -32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
